divider_unit: RTL and testbench

Multi-cycle iterative restoring divider placed directly upstream of the HiLo register.
- Accepts a 32-bit dividend and divisor on a start strobe.
- Iterates one quotient bit per clock.
- Presents the packed 64-bit result {remainder, quotient} with a one-cycle done pulse that drives the HiLo write-enable (Signal).
- Remainder lands in Hi, quotient in Lo.

---
 rtl/divider_unit.sv | 148 ++++++++++++++
 tb/tb_divider_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// Iterative restoring divider feeding HiLo: one quotient bit per clock, {remainder, quotient} on DivAns.
// Define DIV_SIGNED_EN to add two's-complement division selected per request by sign_op.
module divider_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               sign_op,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] DivAns,
    output logic               div_by_zero,
    output logic [1:0]         stateDbg
);

    // Handshake: start is accepted only on an edge where the unit is IDLE (busy low);
    // done pulses for one cycle with DivAns/div_by_zero valid, then the unit is IDLE again.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    stateT              state;
    stateT              nextState;
    logic [WIDTH:0]     remReg;
    logic [WIDTH-1:0]   quoReg;
    logic [WIDTH-1:0]   divReg;
    logic [CNT_W-1:0]   counter;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     stepRem;
    logic [WIDTH-1:0]   stepQuo;
    logic [WIDTH-1:0]   dividendIn;
    logic [WIDTH-1:0]   divisorIn;
    logic [WIDTH-1:0]   remOut;
    logic [WIDTH-1:0]   quoOut;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) nextState = RUN;
            RUN: begin
                busy = 1'b1;
                if (counter == CNT_LAST) nextState = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign stateDbg = state;

    // One restoring step: the partial remainder stays below the divisor, so WIDTH bits shift in cleanly.
    always_comb begin
        shifted = {remReg[WIDTH-1:0], quoReg[WIDTH-1]};
        trial   = shifted - {1'b0, divReg};
        if (!trial[WIDTH]) begin
            stepRem = trial;
            stepQuo = {quoReg[WIDTH-2:0], 1'b1};
        end else begin
            stepRem = shifted;
            stepQuo = {quoReg[WIDTH-2:0], 1'b0};
        end
    end

`ifdef DIV_SIGNED_EN
    logic signDividend;
    logic negQuotient;

    always_comb begin
        dividendIn = (sign_op && dividend[WIDTH-1]) ? -dividend : dividend;
        divisorIn  = (sign_op && divisor[WIDTH-1])  ? -divisor  : divisor;
        // A zero divisor must still report all-ones, so the quotient sign fix is suppressed there.
        quoOut     = (negQuotient && !div_by_zero) ? -stepQuo : stepQuo;
        remOut     = signDividend ? -stepRem[WIDTH-1:0] : stepRem[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            signDividend <= 1'b0;
            negQuotient  <= 1'b0;
        end else if (state == IDLE && start) begin
            signDividend <= sign_op & dividend[WIDTH-1];
            negQuotient  <= sign_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        end
    end
`else
    logic unusedSignOp;
    assign unusedSignOp = sign_op;

    always_comb begin
        dividendIn = dividend;
        divisorIn  = divisor;
        quoOut     = stepQuo;
        remOut     = stepRem[WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remReg      <= '0;
            quoReg      <= '0;
            divReg      <= '0;
            counter     <= '0;
            DivAns      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remReg      <= '0;
                        quoReg      <= dividendIn;
                        divReg      <= divisorIn;
                        counter     <= '0;
                        div_by_zero <= (divisor == '0);
                    end
                end
                RUN: begin
                    remReg  <= stepRem;
                    quoReg  <= stepQuo;
                    counter <= counter + 1'b1;
                    if (counter == CNT_LAST) DivAns <= {remOut, quoOut};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// Randomized scoreboard bench for divider_unit; expected results come from plain integer division.
module tb_divider_unit;
    localparam int W = 32;

`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic           sign_op;
    logic           busy;
    logic           done;
    logic [2*W-1:0] DivAns;
    logic           div_by_zero;
    logic [1:0]     stateDbg;

    logic [2*W:0]   exp_q[$];
    int             vectors = 0;
    int             miscompares = 0;
    int             cycleCnt = 0;
    int             acceptCycle = 0;
    logic           prevDone = 1'b0;
    logic           lastDz = 1'b0;

    divider_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .sign_op(sign_op), .busy(busy), .done(done), .DivAns(DivAns),
        .div_by_zero(div_by_zero), .stateDbg(stateDbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt++;

    // ---------------- reference model ----------------
    function automatic logic [2*W:0] model(logic [W-1:0] a, logic [W-1:0] b, logic sop);
        logic [W-1:0] q;
        logic [W-1:0] r;
        longint sa;
        longint sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sop && SIGNED_BUILD) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {(b == 0), r, q};
    endfunction

    function automatic void check(string name, logic [2*W-1:0] act, logic [2*W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic sop, bit push);
        waitIdle();
        dividend = a;
        divisor  = b;
        sign_op  = sop;
        start    = 1'b1;
        @(posedge clk);
        #1;
        acceptCycle = cycleCnt;
        if (push) exp_q.push_back(model(a, b, sop));
        start = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            check("done_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic runOne(logic [W-1:0] a, logic [W-1:0] b, logic sop);
        issue(a, b, sop, 1'b1);
        waitDrain();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [2*W:0] e;
        if (reset) begin
            prevDone = 1'b0;
        end else begin
            if (prevDone) begin
                check("done_width", 64'(done), 64'd0);
                check("busy_after_done", 64'(busy), 64'd0);
                check("dz_hold", 64'(div_by_zero), 64'(lastDz));
            end
            if (done) begin
                check("latency", 64'(cycleCnt - acceptCycle), 64'd32);
                check("busy_in_done", 64'(busy), 64'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", DivAns, 64'hDEAD_0000_0000_DEAD ^ DivAns ^ 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("DivAns", DivAns, e[2*W-1:0]);
                    check("div_by_zero", 64'(div_by_zero), 64'(e[2*W]));
                    lastDz = e[2*W];
                end
            end
            prevDone = done;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        sign_op  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_DivAns", DivAns, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        reset = 1'b0;

        runOne(32'd100, 32'd7, 1'b0);
        runOne(32'hFFFF_FFFF, 32'd1, 1'b0);
        runOne(32'd3, 32'hFFFF_FFFF, 1'b0);
        runOne(32'd5, 32'd0, 1'b0);

        // Second request during RUN must not disturb operands or produce a second done.
        issue(32'd100, 32'd7, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDrain();
        repeat (3) @(negedge clk);

        // Reset mid-operation: outputs clear immediately and no done follows.
        issue(32'd100, 32'd7, 1'b0, 1'b0);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_DivAns", DivAns, 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_dz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        runOne(32'd9, 32'd3, 1'b0);

`ifdef DIV_SIGNED_EN
        runOne(32'hFFFF_FFF9, 32'd2, 1'b1);
        runOne(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        runOne(32'hFFFF_FFF9, 32'd2, 1'b0);
        runOne(32'hFFFF_FFF9, 32'd0, 1'b1);
        runOne(32'd7, 32'hFFFF_FFFE, 1'b1);
`endif

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 16));
                3:       b = a;
                default: b = $urandom;
            endcase
            runOne(a, b, 1'(($urandom_range(0, 1))));
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
